// File: rtl/mp3_pkg.sv
// Shared constants, types and attenuation helpers for the MP3 player control block.
package mp3_pkg;

  localparam logic [7:0]  VOL_MIN       = 8'h00;
  localparam logic [7:0]  VOL_MAX       = 8'hFE;
  localparam logic [15:0] VOL_MUTE_WORD = 16'hFEFE;
  localparam int          SONG_W        = 3;

  typedef logic [SONG_W-1:0] song_idx_t;

  // Auto-repeat timer phase: first wait is the long delay, then the short period.
  typedef enum logic {
    RPT_DELAY  = 1'b0,
    RPT_PERIOD = 1'b1
  } rpt_phase_e;

  // Louder: smaller attenuation, clamped at the loudest setting.
  function automatic logic [7:0] att_dec(input logic [7:0] att, input logic [7:0] step);
    logic [8:0] diff;
    diff = {1'b0, att} - {1'b0, step};
    return diff[8] ? VOL_MIN : diff[7:0];
  endfunction

  // Quieter: larger attenuation, computed 9 bits wide and clamped at silence.
  function automatic logic [7:0] att_inc(input logic [7:0] att, input logic [7:0] step);
    logic [8:0] sum;
    sum = {1'b0, att} + {1'b0, step};
    return (sum > {1'b0, VOL_MAX}) ? VOL_MAX : sum[7:0];
  endfunction

endpackage

// File: rtl/mp3_ctrl_btn_debounce.sv
// Button front end: 2-flop synchronizer, debounce counter, press pulse and
// optional hold-to-repeat pulse train.
module btn_debounce
  import mp3_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter bit          REPEAT_EN       = 1'b0,
  parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_event
);

  logic        r_sync1;
  logic        r_sync2;
  logic        r_level;
  logic        r_level_d;
  logic [19:0] r_cnt;
  logic [24:0] r_rpt_cnt;
  rpt_phase_e  r_phase;
  logic        w_press;
  logic        w_rpt_hit;

  assign w_press = r_level & ~r_level_d;
  assign o_event = w_press | w_rpt_hit;

  // Synchronize the raw button and accept a new level after enough differing samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= 20'd0;
    end else begin
      r_sync1   <= i_btn;
      r_sync2   <= r_sync1;
      r_level_d <= r_level;
      if (r_sync2 == r_level) begin
        r_cnt <= 20'd0;
      end else if (r_cnt == DEBOUNCE_CYCLES - 20'd1) begin
        r_level <= r_sync2;
        r_cnt   <= 20'd0;
      end else begin
        r_cnt <= r_cnt + 20'd1;
      end
    end
  end

  // Decide whether the repeat timer has reached the target of its current phase.
  always_comb begin
    w_rpt_hit = 1'b0;
    if (REPEAT_EN && r_level && !w_press) begin
      if (r_phase == RPT_DELAY) begin
        w_rpt_hit = (r_rpt_cnt == REPEAT_DELAY);
      end else begin
        w_rpt_hit = (r_rpt_cnt == {1'b0, REPEAT_PERIOD});
      end
    end else begin
      w_rpt_hit = 1'b0;
    end
  end

  // Repeat timer: counts cycles since the last event while the button stays held.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rpt_cnt <= 25'd0;
      r_phase   <= RPT_DELAY;
    end else if (REPEAT_EN == 1'b0 || r_level == 1'b0) begin
      r_rpt_cnt <= 25'd0;
      r_phase   <= RPT_DELAY;
    end else if (w_press) begin
      r_rpt_cnt <= 25'd1;
      r_phase   <= RPT_DELAY;
    end else if (w_rpt_hit) begin
      r_rpt_cnt <= 25'd1;
      r_phase   <= RPT_PERIOD;
    end else begin
      r_rpt_cnt <= r_rpt_cnt + 25'd1;
    end
  end

endmodule

// File: rtl/mp3_ctrl.sv
// MP3 player control: debounced buttons drive the VS1003B volume word,
// mute state and the current song index.
module mp3_ctrl
  import mp3_pkg::*;
#(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [24:0] REPEAT_DELAY    = 25'd25000000,
  parameter logic [23:0] REPEAT_PERIOD   = 24'd5000000,
  parameter logic [7:0]  VOL_STEP        = 8'h08,
  parameter logic [7:0]  VOL_INIT        = 8'h20,
  parameter int          NUM_SONGS       = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              btn_vup,
  input  logic              btn_vdn,
  input  logic              btn_next,
  input  logic              btn_prev,
  input  logic              btn_mute,
  output logic [15:0]       vol,
  output logic [SONG_W-1:0] current,
  output logic              song_chg,
  output logic              vol_chg,
  output logic              muted
);

  localparam song_idx_t LAST_SONG = song_idx_t'(NUM_SONGS - 1);

  logic        w_vup_ev, w_vdn_ev, w_next_ev, w_prev_ev, w_mute_ev;
  logic [7:0]  r_att;
  logic        r_muted;
  logic [15:0] r_vol;
  logic        r_vol_chg;
  song_idx_t   r_cur;
  logic        r_song_chg;
  logic [7:0]  w_att_nxt;
  logic        w_muted_nxt;
  logic [15:0] w_vol_nxt;
  song_idx_t   w_cur_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                 .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_vup  (.i_clk(CLK), .i_rst(RST), .i_btn(btn_vup),  .o_event(w_vup_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b1),
                 .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD))
    u_vdn  (.i_clk(CLK), .i_rst(RST), .i_btn(btn_vdn),  .o_event(w_vdn_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0))
    u_next (.i_clk(CLK), .i_rst(RST), .i_btn(btn_next), .o_event(w_next_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0))
    u_prev (.i_clk(CLK), .i_rst(RST), .i_btn(btn_prev), .o_event(w_prev_ev));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .REPEAT_EN(1'b0))
    u_mute (.i_clk(CLK), .i_rst(RST), .i_btn(btn_mute), .o_event(w_mute_ev));

  // Next attenuation, mute state and output word; simultaneous up/down cancels.
  always_comb begin
    w_att_nxt   = r_att;
    w_muted_nxt = r_muted ^ w_mute_ev;
    w_vol_nxt   = r_vol;
    if (w_vup_ev && !w_vdn_ev) begin
      w_att_nxt = att_dec(r_att, VOL_STEP);
    end else if (w_vdn_ev && !w_vup_ev) begin
      w_att_nxt = att_inc(r_att, VOL_STEP);
    end else begin
      w_att_nxt = r_att;
    end
    if (w_muted_nxt) begin
      w_vol_nxt = VOL_MUTE_WORD;
    end else begin
      w_vol_nxt = {w_att_nxt, w_att_nxt};
    end
  end

  // Next song index with wrap-around; simultaneous next/prev cancels.
  always_comb begin
    w_cur_nxt = r_cur;
    if (w_next_ev && !w_prev_ev) begin
      w_cur_nxt = (r_cur == LAST_SONG) ? song_idx_t'(3'd0) : r_cur + song_idx_t'(3'd1);
    end else if (w_prev_ev && !w_next_ev) begin
      w_cur_nxt = (r_cur == song_idx_t'(3'd0)) ? LAST_SONG : r_cur - song_idx_t'(3'd1);
    end else begin
      w_cur_nxt = r_cur;
    end
  end

  // Register volume/mute/song state and flag real output changes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_att      <= VOL_INIT;
      r_muted    <= 1'b0;
      r_vol      <= {VOL_INIT, VOL_INIT};
      r_vol_chg  <= 1'b0;
      r_cur      <= song_idx_t'(3'd0);
      r_song_chg <= 1'b0;
    end else begin
      r_att      <= w_att_nxt;
      r_muted    <= w_muted_nxt;
      r_vol      <= w_vol_nxt;
      r_vol_chg  <= (w_vol_nxt != r_vol);
      r_cur      <= w_cur_nxt;
      r_song_chg <= (w_cur_nxt != r_cur);
    end
  end

  assign vol      = r_vol;
  assign vol_chg  = r_vol_chg;
  assign muted    = r_muted;
  assign current  = r_cur;
  assign song_chg = r_song_chg;

endmodule

// File: tb/tb_mp3_ctrl.sv
// Directed bench for mp3_ctrl with a pulse-driven scoreboard.
module tb_mp3_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        btn_vup = 1'b0, btn_vdn = 1'b0, btn_next = 1'b0, btn_prev = 1'b0, btn_mute = 1'b0;
  logic [15:0] vol;
  logic [2:0]  current;
  logic        song_chg, vol_chg, muted;

  int checks = 0;
  int errors = 0;

  logic [15:0] vol_q[$];
  logic [2:0]  song_q[$];
  logic [7:0]  m_att   = 8'h20;
  logic        m_muted = 1'b0;
  logic [2:0]  m_cur   = 3'd0;

  localparam int B_VUP = 0, B_VDN = 1, B_NEXT = 2, B_PREV = 3, B_MUTE = 4;

  mp3_ctrl #(
    .DEBOUNCE_CYCLES(20'd4), .REPEAT_DELAY(25'd16), .REPEAT_PERIOD(24'd4), .NUM_SONGS(5)
  ) dut (
    .CLK(CLK), .RST(RST), .btn_vup(btn_vup), .btn_vdn(btn_vdn), .btn_next(btn_next),
    .btn_prev(btn_prev), .btn_mute(btn_mute), .vol(vol), .current(current),
    .song_chg(song_chg), .vol_chg(vol_chg), .muted(muted)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_word();
    return m_muted ? 16'hFEFE : {m_att, m_att};
  endfunction

  task automatic model_vol(input bit up);
    logic [15:0] old_w;
    old_w = m_word();
    if (up) m_att = (m_att < 8'h08) ? 8'h00 : m_att - 8'h08;
    else    m_att = (m_att > 8'hF6) ? 8'hFE : m_att + 8'h08;
    if (m_word() != old_w) vol_q.push_back(m_word());
  endtask

  task automatic model_mute();
    logic [15:0] old_w;
    old_w = m_word();
    m_muted = ~m_muted;
    if (m_word() != old_w) vol_q.push_back(m_word());
  endtask

  task automatic model_song(input bit nxt);
    if (nxt) m_cur = (m_cur == 3'd4) ? 3'd0 : m_cur + 3'd1;
    else     m_cur = (m_cur == 3'd0) ? 3'd4 : m_cur - 3'd1;
    song_q.push_back(m_cur);
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_VUP:   btn_vup  = v;
      B_VDN:   btn_vdn  = v;
      B_NEXT:  btn_next = v;
      B_PREV:  btn_prev = v;
      default: btn_mute = v;
    endcase
  endtask

  task automatic press(input int b);
    @(negedge CLK); set_btn(b, 1'b1);
    repeat (8) @(negedge CLK);
    set_btn(b, 1'b0);
    repeat (10) @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_vol"}, vol, 16'h2020);
    chk({tag, "_current"}, {13'd0, current}, 16'd0);
    chk({tag, "_muted"}, {15'd0, muted}, 16'd0);
    chk({tag, "_vol_chg"}, {15'd0, vol_chg}, 16'd0);
    chk({tag, "_song_chg"}, {15'd0, song_chg}, 16'd0);
  endtask

  task automatic do_reset();
    @(negedge CLK); RST = 1'b1;
    #1;
    check_reset_outputs("reset");
    m_att = 8'h20; m_muted = 1'b0; m_cur = 3'd0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
  endtask

  task automatic wait_vol_chg(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      seen = vol_chg;
    end
    chk(tag, {15'd0, seen}, 16'd1);
  endtask

  // Scoreboard: every change pulse must match the next expected value.
  always @(negedge CLK) begin
    if (!RST && vol_chg) begin
      chk("vol_chg_expected", {15'd0, vol_q.size() != 0}, 16'd1);
      if (vol_q.size() != 0) chk("vol_on_chg", vol, vol_q.pop_front());
    end
    if (!RST && song_chg) begin
      chk("song_chg_expected", {15'd0, song_q.size() != 0}, 16'd1);
      if (song_q.size() != 0) chk("current_on_chg", {13'd0, current}, {13'd0, song_q.pop_front()});
    end
  end

  initial begin
    repeat (3) @(negedge CLK);
    check_reset_outputs("init");
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Two-cycle glitch must be rejected.
    btn_vup = 1'b1;
    repeat (2) @(negedge CLK);
    btn_vup = 1'b0;
    repeat (12) @(negedge CLK);
    chk("glitch_vol", vol, 16'h2020);

    // Five volume-up presses, saturating at loudest.
    for (int i = 0; i < 5; i++) begin
      model_vol(1'b1);
      press(B_VUP);
    end
    chk("vup_sat_vol", vol, 16'h0000);
    chk("vup_queue_drained", 16'(vol_q.size()), 16'd0);

    do_reset();

    // Song stepping with wrap in both directions.
    for (int i = 0; i < 5; i++) begin
      model_song(1'b1);
      press(B_NEXT);
    end
    chk("next_wrap_current", {13'd0, current}, 16'd0);
    model_song(1'b0);
    press(B_PREV);
    chk("prev_wrap_current", {13'd0, current}, 16'd4);
    chk("song_queue_drained", 16'(song_q.size()), 16'd0);

    // Hold volume-down: press event plus six auto-repeats.
    for (int i = 0; i < 7; i++) model_vol(1'b0);
    @(negedge CLK); btn_vdn = 1'b1;
    wait_vol_chg("vdn_first_event");
    repeat (32) @(negedge CLK);
    btn_vdn = 1'b0;
    repeat (20) @(negedge CLK);
    chk("vdn_hold_vol", vol, 16'h5858);
    chk("vdn_queue_drained", 16'(vol_q.size()), 16'd0);

    do_reset();

    // Mute hides the word while volume changes continue underneath.
    model_mute();
    press(B_MUTE);
    chk("mute_vol", vol, 16'hFEFE);
    chk("mute_flag", {15'd0, muted}, 16'd1);
    model_vol(1'b1);
    press(B_VUP);
    chk("muted_vup_vol", vol, 16'hFEFE);
    model_mute();
    press(B_MUTE);
    chk("unmute_vol", vol, 16'h1818);
    chk("unmute_flag", {15'd0, muted}, 16'd0);

    // Simultaneous next and prev cancel each other.
    model_song(1'b1);
    press(B_NEXT);
    @(negedge CLK); btn_next = 1'b1; btn_prev = 1'b1;
    repeat (8) @(negedge CLK);
    btn_next = 1'b0; btn_prev = 1'b0;
    repeat (10) @(negedge CLK);
    chk("next_prev_same_cycle", {13'd0, current}, 16'd1);

    // Reset while volume-up is held, then one press after release of reset.
    model_vol(1'b1);
    @(negedge CLK); btn_vup = 1'b1;
    wait_vol_chg("vup_hold_event");
    repeat (5) @(negedge CLK);
    RST = 1'b1;
    #1;
    check_reset_outputs("mid_hold_reset");
    m_att = 8'h20; m_muted = 1'b0; m_cur = 3'd0;
    repeat (3) @(negedge CLK);
    model_vol(1'b1);
    RST = 1'b0;
    repeat (10) @(negedge CLK);
    btn_vup = 1'b0;
    repeat (20) @(negedge CLK);
    chk("held_through_reset_vol", vol, 16'h1818);
    chk("final_vol_queue", 16'(vol_q.size()), 16'd0);
    chk("final_song_queue", 16'(song_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mp3_ctrl.md
MP3_CTRL -- requirements
Module: mp3_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 20'd500000, consecutive equal samples needed to accept a new button level.
REQ-002 Parameter REPEAT_DELAY, default 25'd25000000, hold time before a volume button auto-repeats.
REQ-003 Parameter REPEAT_PERIOD, default 24'd5000000, auto-repeat interval after REPEAT_DELAY.
REQ-004 Parameter VOL_STEP, default 8'h08, attenuation change per volume event.
REQ-005 Parameter VOL_INIT, default 8'h20, per-channel attenuation after reset.
REQ-006 Parameter NUM_SONGS, default 5, song count; legal range 1..8.
REQ-007 CLK  in  1  single system clock, all logic on its rising edge.
REQ-008 RST  in  1  reset; asynchronous and active-high.
REQ-009 btn_vup, btn_vdn, btn_next, btn_prev, btn_mute  in  1 each  raw asynchronous board buttons, high = pressed.
REQ-010 vol  out  16  VS1003B SCI_VOL word {left_att, right_att}; 0x00 = loudest, 0xFE = silent.
REQ-011 current  out  3  index of the song to play, 0..NUM_SONGS-1.
REQ-012 song_chg  out  1  one-cycle pulse in the cycle current takes a new value.
REQ-013 vol_chg  out  1  one-cycle pulse in the cycle vol takes a new value.
REQ-014 muted  out  1  high while mute is active.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that updates its debounced level only after DEBOUNCE_CYCLES consecutive synchronized samples differ from the current level; the counter clears on any sample equal to the current level.
REQ-016 A press event SHALL be a one-cycle pulse on the 0->1 transition of a debounced level; releases generate no event.
REQ-017 For btn_vup/btn_vdn only, while the debounced level stays high, an additional event SHALL fire REPEAT_DELAY cycles after the press event and then every REPEAT_PERIOD cycles until release.
REQ-018 Outputs SHALL be registered and update on the clock edge after the event pulse (latency 1 cycle from event).
REQ-019 vup event: att = att - VOL_STEP, saturating at 0x00; vdn event: att = att + VOL_STEP, saturating at 0xFE, computed 9 bits wide before clamping.
REQ-020 vup and vdn events in the same cycle SHALL both be ignored.
REQ-021 mute event SHALL toggle muted; while muted vol = 16'hFEFE and the stored att is held; vup/vdn events while muted SHALL still update the stored att.
REQ-022 vol SHALL equal {att, att} when not muted.
REQ-023 next event: current = (current == NUM_SONGS-1) ? 0 : current+1; prev event: current = (current == 0) ? NUM_SONGS-1 : current-1.
REQ-024 next and prev events in the same cycle SHALL both be ignored.
REQ-025 song_chg SHALL pulse only when current actually changes (no pulse when NUM_SONGS = 1).
REQ-026 vol_chg SHALL pulse only when the vol output value changes (no pulse on saturated steps; pulse on every mute toggle unless att already 0xFE).

Reset
REQ-027 On RST high, asynchronously: att = VOL_INIT, vol = {VOL_INIT, VOL_INIT}, current = 0, muted = 0, song_chg = 0, vol_chg = 0, synchronizers/debounced levels = 0, all counters = 0.
REQ-028 A button held through reset release SHALL generate exactly one press event after debouncing; reset mid-repeat SHALL cancel the repeat.

Structure
REQ-029 A shared package mp3_pkg SHALL hold VOL_MIN (8'h00), VOL_MAX (8'hFE), VOL_MUTE_WORD (16'hFEFE) and the song-index width (3).
REQ-030 One sub-module btn_debounce (synchronizer, debounce counter, rise pulse, optional auto-repeat enabled by parameter) SHALL be instantiated five times.

Verification (bench: DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=4, NUM_SONGS=5)
REQ-031 Reset -> vol=16'h2020, current=0, muted=0; 2-cycle glitch on btn_vup -> no change, no vol_chg.
REQ-032 Press btn_vup 5 times from reset -> vol 0x1818, 0x1010, 0x0808, 0x0000, 0x0000; vol_chg on first four only.
REQ-033 Press btn_next 5 times -> current 1,2,3,4,0 with 5 song_chg pulses; then btn_prev once -> current 4.
REQ-034 Hold btn_vdn 40 cycles after debounce -> events at press, +16, +20, +24, +28, +32, +36 -> att 0x20+7*8=0x58.
REQ-035 Press btn_mute -> vol=16'hFEFE, muted=1; press btn_vup -> vol stays 16'hFEFE; press btn_mute -> vol=16'h1818.
REQ-036 btn_next and btn_prev debounced in the same cycle -> current unchanged, no song_chg; assert RST mid-hold of btn_vup -> outputs return to reset values immediately.
